matrix_result_drain: RTL and testbench
======================================

Name: matrix_result_drain

Overview:
- Downstream stage of the 4x4 matrix multiplier.
- Detects completion of a multiply (falling edge of the multiplier's busy flag) and captures the packed 16-bit product matrix.
- Either loads the products or accumulates them into a bank of saturating accumulators.
- Streams the accumulator contents out one element per transfer over a valid/ready interface, so results can reach a narrow bus or memory writer.

Parameters:
- row, 4, matrix rows (same as multiplier)
- col, 4, matrix columns (same as multiplier)
- aw, 24, accumulator and output element width in bits (must be >= 16)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- busy_M  in  1  multiplier busy flag; a 1->0 transition marks in_M valid
- in_M  in  16*row*col  packed unsigned products; element i = in_M[16*i +: 16], row-major
- acc_en  in  1  sampled at capture: 1 = add into accumulators, 0 = load and stream
- flush  in  1  one-cycle pulse in IDLE: stream current accumulators
- out_data  out  aw  current element value
- out_idx  out  clog2(row*col)  row-major index of out_data
- out_valid  out  1  element presented
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_last  out  1  out_valid & (out_idx == row*col-1)
- busy_D  out  1  high while in STREAM
- overrun  out  1  sticky: a capture event was dropped

Behaviour:
- Reset (synchronous, while reset=1 at a rising edge):
  - out_valid=0, out_last=0, busy_D=0, overrun=0, out_idx=0, out_data=0.
  - All accumulators=0, busy_q=0, state=IDLE.
  - Reset mid-stream aborts the stream; out_valid is 0 from the next cycle.
- Done detection: busy_q registers busy_M every cycle. done = busy_q & ~busy_M, evaluated combinationally at the sampling edge.
- IDLE state, done=1 and acc_en=0:
  - acc[i] <= zero-extended in_M element i.
  - state <= STREAM, out_idx <= 0.
  - out_valid=1 in the cycle after the edge (1-cycle latency).
- IDLE state, done=1 and acc_en=1:
  - acc[i] <= sat(acc[i] + in_M[i]).
  - Stay in IDLE; no stream.
- IDLE state, flush=1 and done=0: state <= STREAM, out_idx <= 0.
- IDLE state, done and flush in the same cycle: done is processed as above and flush is discarded.
- STREAM state:
  - out_valid=1, busy_D=1, out_data=acc[out_idx].
  - On out_valid & out_ready: out_idx increments.
  - On the transfer with out_idx==row*col-1: all acc <= 0, out_idx <= 0, state <= IDLE.
  - out_valid drops the cycle after the last transfer.
  - With out_ready held low, out_data and out_idx stay stable.
- Events during STREAM:
  - done=1: data discarded, overrun <= 1 (sticky until reset); stream continues unaffected.
  - flush is ignored.
- Saturation:
  - Sum is computed at aw+1 bits.
  - If the sum exceeds 2^aw-1, result = 2^aw-1; no wrap-around.
  - All values unsigned.
- busy_M held high or held low generates no events; only one capture per falling edge.
- Minimum stream duration is row*col cycles with out_ready tied high; back-to-back streams possible (next done may arrive the cycle after return to IDLE).

Test Plan:
- Reset then idle with busy_M=0 -> out_valid=0, busy_D=0, overrun=0, out_data=0 for 10 cycles.
- in_M all elements 0x0190, busy_M 1->0, acc_en=0, out_ready=1 -> 16 transfers on consecutive cycles, out_data=0x000190, out_idx 0..15, out_last only on idx 15, busy_D low after.
- in_M element i = i+1, acc_en=1, two done events, then flush -> stream returns 2*(i+1) at idx i; accumulators read 0 afterwards (second flush streams all zeros).
- aw=17, in_M all 0xFFFF, acc_en=1, three done events, flush -> every element 0x1FFFF (third add saturates).
- out_ready toggled 1,0,0,1,... during stream -> no element skipped or duplicated, data stable while stalled, 16 transfers total.
- done during STREAM -> overrun=1 and remains 1, current stream values unchanged; reset asserted mid-stream -> out_valid=0 next cycle, overrun cleared, accumulators zero.

Source files
------------

// File: rtl/matrix_result_drain_if.sv
// Result stream from the matrix drain: one accumulator element per valid/ready transfer.
interface matrix_result_drain_if #(
  parameter int aw = 24,
  parameter int n  = 16
);
  localparam int iw = (n > 1) ? $clog2(n) : 1;

  logic [aw-1:0] out_data;
  logic [iw-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, out_idx, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_idx, out_valid, out_last, output out_ready);
endinterface

// File: rtl/matrix_result_drain.sv
// Captures each finished 4x4 product, loads or saturating-accumulates it, and
// streams the accumulator bank out element by element.
module matrix_result_drain #(
  parameter int row = 4,
  parameter int col = 4,
  parameter int aw  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    busy_M,
  input  logic [16*row*col-1:0]   in_M,
  input  logic                    acc_en,
  input  logic                    flush,
  matrix_result_drain_if.master   o,
  output logic                    busy_D,
  output logic                    overrun
);
  localparam int N  = row * col;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic            busy_q;
  logic            done;
  logic            valid_q;
  logic [IW-1:0]   idx_q;
  logic [aw-1:0]   acc [N];

  function automatic logic [aw-1:0] sat_add(input logic [aw-1:0] a, input logic [15:0] b);
    logic [aw:0] sum;
    sum = {1'b0, a} + (aw+1)'(b);
    return sum[aw] ? {aw{1'b1}} : sum[aw-1:0];
  endfunction

  // A multiply has finished on the cycle its busy flag falls.
  assign done = busy_q & ~busy_M;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy_D  <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else begin
      busy_q <= busy_M;
      case (state)
        IDLE: begin
          if (done) begin
            for (int i = 0; i < N; i++)
              acc[i] <= acc_en ? sat_add(acc[i], in_M[16*i +: 16]) : aw'(in_M[16*i +: 16]);
            if (!acc_en) begin
              state   <= STREAM;
              valid_q <= 1'b1;
              busy_D  <= 1'b1;
              idx_q   <= '0;
            end
          end else if (flush) begin
            state   <= STREAM;
            valid_q <= 1'b1;
            busy_D  <= 1'b1;
            idx_q   <= '0;
          end
        end
        STREAM: begin
          // Products finishing mid-stream cannot be held anywhere; flag the loss.
          if (done) overrun <= 1'b1;
          if (o.out_ready) begin
            if (idx_q == IW'(N-1)) begin
              for (int i = 0; i < N; i++) acc[i] <= '0;
              idx_q   <= '0;
              state   <= IDLE;
              valid_q <= 1'b0;
              busy_D  <= 1'b0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o.out_valid = valid_q;
  assign o.out_idx   = idx_q;
  assign o.out_data  = valid_q ? acc[idx_q] : '0;
  assign o.out_last  = valid_q && (idx_q == IW'(N-1));
endmodule

// File: tb/tb_matrix_result_drain.sv
// Randomized bench for matrix_result_drain: a 24-bit and a 17-bit instance
// compared against an array model of load / saturating-accumulate / stream.
module tb_matrix_result_drain;
  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic         reset;
  logic         busy_M0, acc_en0, flush0, busy_D0, overrun0;
  logic         busy_M1, acc_en1, flush1, busy_D1, overrun1;
  logic [255:0] in_M0, in_M1;

  matrix_result_drain_if #(.aw(24), .n(16)) if0 ();
  matrix_result_drain_if #(.aw(17), .n(16)) if1 ();

  matrix_result_drain #(.row(4), .col(4), .aw(24)) dut0 (
    .clk(tb_clk), .reset(reset), .busy_M(busy_M0), .in_M(in_M0), .acc_en(acc_en0),
    .flush(flush0), .o(if0), .busy_D(busy_D0), .overrun(overrun0));
  matrix_result_drain #(.row(4), .col(4), .aw(17)) dut1 (
    .clk(tb_clk), .reset(reset), .busy_M(busy_M1), .in_M(in_M1), .acc_en(acc_en1),
    .flush(flush1), .o(if1), .busy_D(busy_D1), .overrun(overrun1));

  int checks = 0;
  int errors = 0;

  // reference model: accumulator contents per instance, expected stream
  longint mdl0 [16];
  longint mdl1 [16];
  longint expv [16];
  int     vals [16];

  logic [23:0] got_data [16];
  int got_n, bad_idx, bad_last, bad_stall, span;
  logic after_valid;

  function automatic logic [255:0] pack_vals();
    logic [255:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[16*i +: 16] = vals[i][15:0];
    return p;
  endfunction

  // Model of one capture event in IDLE; returns 1 when it starts a stream.
  function automatic bit model_capture(input int sel, input bit e);
    longint mx;
    mx = sel ? 64'h1FFFF : 64'hFFFFFF;
    for (int i = 0; i < 16; i++) begin
      if (sel == 0) begin
        if (e) mdl0[i] = (mdl0[i] + vals[i] > mx) ? mx : mdl0[i] + vals[i];
        else begin expv[i] = vals[i]; mdl0[i] = 0; end
      end else begin
        if (e) mdl1[i] = (mdl1[i] + vals[i] > mx) ? mx : mdl1[i] + vals[i];
        else begin expv[i] = vals[i]; mdl1[i] = 0; end
      end
    end
    return !e;
  endfunction

  function automatic void model_flush(input int sel);
    for (int i = 0; i < 16; i++) begin
      expv[i] = sel ? mdl1[i] : mdl0[i];
      if (sel == 0) mdl0[i] = 0; else mdl1[i] = 0;
    end
  endfunction

  task automatic capture(input int sel, input bit e, input int hold);
    @(negedge tb_clk);
    if (sel == 0) begin in_M0 = pack_vals(); acc_en0 = e; busy_M0 = 1'b1; end
    else          begin in_M1 = pack_vals(); acc_en1 = e; busy_M1 = 1'b1; end
    repeat (hold - 1) @(negedge tb_clk);
    @(negedge tb_clk);
    if (sel == 0) busy_M0 = 1'b0; else busy_M1 = 1'b0;
    @(negedge tb_clk);
  endtask

  task automatic pulse_flush(input int sel);
    @(negedge tb_clk);
    if (sel == 0) flush0 = 1'b1; else flush1 = 1'b1;
    @(negedge tb_clk);
    if (sel == 0) flush0 = 1'b0; else flush1 = 1'b0;
  endtask

  // Acts as the downstream sink; mode 0 ready high, 1 pattern 1,0,0, 2 random.
  task automatic drain(input int sel, input int mode);
    int cyc;
    bit pstall, started, rdy, v, l;
    logic [23:0] d, pdata;
    logic [3:0] i, pidx;
    got_n = 0; bad_idx = 0; bad_last = 0; bad_stall = 0; span = 0;
    cyc = 0; pstall = 0; started = 0; pdata = '0; pidx = '0;
    while (got_n < 16 && cyc < 400) begin
      @(negedge tb_clk);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (sel == 0) if0.out_ready = rdy; else if1.out_ready = rdy;
      v = sel ? if1.out_valid : if0.out_valid;
      d = sel ? 24'(if1.out_data) : if0.out_data;
      i = sel ? if1.out_idx : if0.out_idx;
      l = sel ? if1.out_last : if0.out_last;
      if (pstall && (d !== pdata || i !== pidx)) bad_stall++;
      if (l !== (v && i == 4'd15)) bad_last++;
      if (v) started = 1;
      if (started) span++;
      if (v && rdy) begin
        if (i !== got_n[3:0]) bad_idx++;
        got_data[got_n] = d;
        got_n++;
      end
      pstall = v && !rdy; pdata = d; pidx = i;
      cyc++;
    end
    @(negedge tb_clk);
    after_valid = sel ? if1.out_valid : if0.out_valid;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge tb_clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_clk);
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if0.out_valid); end
      checks++; if (busy_D0 !== 1'b0) begin errors++; $display("FAIL reset_busy_D got %b exp 0", busy_D0); end
      checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun0); end
      checks++; if (if0.out_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 0", if0.out_data); end
      checks++; if (if0.out_idx !== 4'd0 || if0.out_last !== 1'b0) begin errors++; $display("FAIL reset_idx_last got %0d/%b exp 0/0", if0.out_idx, if0.out_last); end
    end
  endtask

  task automatic check_stream(input string name, input int sel, input bit tight);
    checks++; if (got_n !== 16) begin errors++; $display("FAIL %s_count got %0d exp 16", name, got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_data[k] !== 24'(expv[k])) begin errors++; $display("FAIL %s_data[%0d] got %h exp %h", name, k, got_data[k], 24'(expv[k])); end
    end
    checks++; if (bad_idx !== 0) begin errors++; $display("FAIL %s_idx got %0d bad exp 0", name, bad_idx); end
    checks++; if (bad_last !== 0) begin errors++; $display("FAIL %s_last got %0d bad exp 0", name, bad_last); end
    checks++; if (bad_stall !== 0) begin errors++; $display("FAIL %s_stall got %0d bad exp 0", name, bad_stall); end
    checks++; if (after_valid !== 1'b0) begin errors++; $display("FAIL %s_drop got %b exp 0", name, after_valid); end
    if (tight) begin
      checks++; if (span !== 16) begin errors++; $display("FAIL %s_span got %0d exp 16", name, span); end
    end
    checks++; if ((sel ? busy_D1 : busy_D0) !== 1'b0) begin errors++; $display("FAIL %s_busy_after got 1 exp 0", name); end
  endtask

  task automatic test_load_stream;
    for (int i = 0; i < 16; i++) vals[i] = 16'h0190;
    void'(model_capture(0, 1'b0));
    capture(0, 1'b0, 1);
    checks++; if (busy_D0 !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy_D0); end
    drain(0, 0);
    check_stream("load", 0, 1'b1);
  endtask

  task automatic test_accumulate;
    for (int i = 0; i < 16; i++) vals[i] = i + 1;
    for (int r = 0; r < 2; r++) begin
      void'(model_capture(0, 1'b1));
      capture(0, 1'b1, 1);
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL acc_nostream got %b exp 0", if0.out_valid); end
    end
    model_flush(0);
    pulse_flush(0);
    drain(0, 0);
    check_stream("acc", 0, 1'b1);
    model_flush(0);
    pulse_flush(0);
    drain(0, 2);
    check_stream("acc_zero", 0, 1'b0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 16; i++) vals[i] = 16'hFFFF;
    for (int r = 0; r < 3; r++) begin void'(model_capture(1, 1'b1)); capture(1, 1'b1, 1); end
    model_flush(1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (expv[i] !== 64'h1FFFF) begin errors++; $display("FAIL sat_model[%0d] got %h exp 1ffff", i, expv[i]); end
    end
    pulse_flush(1);
    drain(1, 0);
    check_stream("sat", 1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) vals[i] = $urandom_range(16'h8000, 16'hFFFF);
      void'(model_capture(1, 1'b1));
      capture(1, 1'b1, 1 + (r % 2));
    end
    model_flush(1);
    pulse_flush(1);
    drain(1, 2);
    check_stream("sat_rand", 1, 1'b0);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 16'hFFFF);
    void'(model_capture(0, 1'b0));
    capture(0, 1'b0, 1);
    drain(0, 1);
    check_stream("stall", 0, 1'b0);
  endtask

  task automatic test_random;
    bit e;
    for (int r = 0; r < 8; r++) begin
      e = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 16'hFFFF);
      void'(model_capture(0, e));
      capture(0, e, $urandom_range(1, 3));
      if (!e) begin
        drain(0, 2);
        check_stream("rand_load", 0, 1'b0);
      end else begin
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rand_acc_nostream got %b exp 0", if0.out_valid); end
      end
    end
    model_flush(0);
    pulse_flush(0);
    drain(0, 2);
    check_stream("rand_flush", 0, 1'b0);
  endtask

  task automatic test_done_flush_collision;
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 16'hFFFF);
    void'(model_capture(0, 1'b1));
    @(negedge tb_clk);
    in_M0 = pack_vals(); acc_en0 = 1'b1; busy_M0 = 1'b1;
    @(negedge tb_clk);
    busy_M0 = 1'b0; flush0 = 1'b1;
    @(negedge tb_clk);
    flush0 = 1'b0;
    repeat (2) @(negedge tb_clk);
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL collide_nostream got %b exp 0", if0.out_valid); end
    model_flush(0);
    pulse_flush(0);
    drain(0, 0);
    check_stream("collide", 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    int vb [16];
    for (int i = 0; i < 16; i++) begin vals[i] = $urandom_range(0, 16'hFFFF); vb[i] = $urandom_range(0, 16'hFFFF); end
    void'(model_capture(0, 1'b0));
    capture(0, 1'b0, 1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge tb_clk);
      if0.out_ready = 1'b1;
      checks++; if (if0.out_idx !== 4'(j) || if0.out_data !== 24'(expv[j])) begin errors++; $display("FAIL b2b_first[%0d] got %0d/%h exp %0d/%h", j, if0.out_idx, if0.out_data, j, 24'(expv[j])); end
      if (j == 15) begin
        for (int i = 0; i < 16; i++) vals[i] = vb[i];
        in_M0 = pack_vals(); acc_en0 = 1'b0; busy_M0 = 1'b1;
      end
    end
    @(negedge tb_clk);
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", if0.out_valid); end
    busy_M0 = 1'b0;
    void'(model_capture(0, 1'b0));
    @(negedge tb_clk);
    if0.out_ready = 1'b0;
    checks++; if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd0) begin errors++; $display("FAIL b2b_restart got %b/%0d exp 1/0", if0.out_valid, if0.out_idx); end
    drain(0, 0);
    check_stream("b2b_second", 0, 1'b1);
  endtask

  task automatic test_overrun_and_reset;
    int a0;
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 16'hFFFF);
    void'(model_capture(0, 1'b0));
    capture(0, 1'b0, 1);
    a0 = int'(expv[0]);
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(0, 16'hFFFF);
    capture(0, 1'b0, 1);
    pulse_flush(0);
    checks++; if (overrun0 !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun0); end
    checks++; if (if0.out_idx !== 4'd0 || if0.out_data !== 24'(a0)) begin errors++; $display("FAIL overrun_hold got %0d/%h exp 0/%h", if0.out_idx, if0.out_data, 24'(a0)); end
    drain(0, 0);
    check_stream("overrun", 0, 1'b1);
    repeat (3) @(negedge tb_clk);
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_noflush got %b exp 0", if0.out_valid); end
    checks++; if (overrun0 !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun0); end
    for (int i = 0; i < 16; i++) vals[i] = $urandom_range(1, 16'hFFFF);
    void'(model_capture(0, 1'b0));
    capture(0, 1'b0, 1);
    if0.out_ready = 1'b1;
    repeat (5) @(negedge tb_clk);
    if0.out_ready = 1'b0; reset = 1'b1;
    @(negedge tb_clk);
    reset = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", if0.out_valid); end
    checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %b exp 0", overrun0); end
    checks++; if (busy_D0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_D0); end
    for (int i = 0; i < 16; i++) begin mdl0[i] = 0; mdl1[i] = 0; end
    model_flush(0);
    pulse_flush(0);
    drain(0, 0);
    check_stream("rst_zero", 0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    busy_M0 = 1'b0; acc_en0 = 1'b0; flush0 = 1'b0; in_M0 = '0;
    busy_M1 = 1'b0; acc_en1 = 1'b0; flush1 = 1'b0; in_M1 = '0;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin mdl0[i] = 0; mdl1[i] = 0; expv[i] = 0; end
    test_reset();
    test_load_stream();
    test_accumulate();
    test_saturation();
    test_stall();
    test_random();
    test_done_flush_collision();
    test_back_to_back();
    test_overrun_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
